vga_rect_plotter: RTL and testbench
===================================

Name: vga_rect_plotter

Overview:
- Parametrised successor to the fixed 4x4 box plotter.
- Rasterises one axis-aligned rectangle of programmable width, height and colour, or a full-screen clear to a programmable colour.
- Emits one pixel per accepted cycle to the VGA adapter write port.
- Sits between the user/control logic (switches, keys, game FSM) and the VGA adapter; adds clipping, back-pressure and a start/busy/done handshake.

Parameters:
- X_SCREEN_PIXELS, 160, screen width in pixels.
- Y_SCREEN_PIXELS, 120, screen height in pixels.
- XW, 8, X coordinate width; must satisfy 2^XW >= X_SCREEN_PIXELS.
- YW, 7, Y coordinate width; must satisfy 2^YW >= Y_SCREEN_PIXELS.
- CW, 3, colour width in bits.
- SZW, 5, width of the rectangle size inputs; maximum size is 2^SZW-1.

Ports:
- iClock  input  1  system clock; all state changes on its rising edge.
- iReset  input  1  asynchronous, active-high reset.
- iStart  input  1  command request; sampled only in IDLE or DONE.
- iClear  input  1  command type: 1 = clear screen, 0 = draw rectangle.
- iX  input  XW  rectangle origin X (top-left).
- iY  input  YW  rectangle origin Y (top-left).
- iW  input  SZW  rectangle width.
- iH  input  SZW  rectangle height.
- iColour  input  CW  fill colour, used for both commands.
- iStall  input  1  adapter back-pressure; when 1, the current pixel is held.
- oX  output  XW  pixel X.
- oY  output  YW  pixel Y.
- oColour  output  CW  pixel colour.
- oPlot  output  1  pixel write enable.
- oBusy  output  1  command in progress.
- oDone  output  1  previous command complete.

Behaviour:
- Reset: asynchronous; while iReset=1, state=IDLE and all outputs (oX, oY, oColour, oPlot, oBusy, oDone) are 0. Reset mid-command abandons it with no further oPlot.
- States:
  - IDLE: no command has run since reset.
  - FILL: rasterising a rectangle.
  - CLEAR: rasterising the full screen.
  - DONE: command finished; oDone held at 1.
- Accept: iStart=1 in IDLE or DONE latches iClear, iX, iY, iW, iH and iColour. Next state is CLEAR if iClear=1, else FILL. oDone drops and oBusy rises on the cycle after acceptance. iStart in FILL or CLEAR is ignored; latched values do not change mid-command.
- Zero size: FILL with iW=0 or iH=0 produces no pixels and goes directly to DONE one cycle after acceptance.
- Raster order: X fastest, then Y.
  - FILL visits offsets (dx, dy), dx=0..W-1, dy=0..H-1, giving oX=X+dx and oY=Y+dy. Sums are computed one bit wider than XW/YW; there is no wrap-around.
  - CLEAR visits x=0..X_SCREEN_PIXELS-1 for each y=0..Y_SCREEN_PIXELS-1.
- Timing: the first pixel is presented the cycle after acceptance, one pixel per cycle while iStall=0. A FILL command takes exactly W*H un-stalled cycles in FILL/CLEAR; a CLEAR command takes X_SCREEN_PIXELS*Y_SCREEN_PIXELS.
- Clipping: a FILL pixel whose wide X >= X_SCREEN_PIXELS or Y >= Y_SCREEN_PIXELS is still stepped through but has oPlot=0. oX/oY then carry the truncated value, which is don't-care. This keeps cycle counts deterministic.
- Stall: while iStall=1, the counters, oX, oY, oColour and oPlot hold their values. Stall in IDLE or DONE has no effect.
- Last pixel: after the last pixel is accepted with iStall=0, the next cycle is DONE with oPlot=0, oBusy=0 and oDone=1. oDone stays high until the next accepted iStart.
- Simultaneous events: iStart together with iStall in DONE is accepted; iStall affects pixel stepping only.

Optional Feature:
- Macro: VGA_RECT_OUTLINE_EN.
- When defined: adds input iOutline (1 bit). With iOutline=1 at acceptance, FILL still steps all W*H positions, but oPlot=1 only where dx=0, dx=W-1, dy=0 or dy=H-1, and only if the pixel is also unclipped. Cycle count is unchanged. CLEAR ignores iOutline.
- When undefined: the port is absent and every unclipped FILL pixel is plotted.

Test Plan:
- Reset during CLEAR at pixel 500 -> within the same cycle all outputs are 0; state is IDLE; no oPlot afterwards.
- FILL X=10, Y=20, W=4, H=4, colour=5, iStall=0 -> 16 consecutive oPlot cycles starting the cycle after iStart. Pixels are (10,20),(11,20)…(13,23), all with oColour=5. oDone rises on cycle 17.
- FILL X=158, Y=118, W=3, H=3 -> 9 stepping cycles; oPlot=1 only at (158,118),(159,118),(158,119),(159,119); oDone after 9 cycles.
- CLEAR colour=0 with iStall toggled 1-of-every-3 cycles -> exactly 19200 oPlot pixels, no duplicates or skips, last pixel (159,119); each stalled cycle holds oX/oY.
- FILL W=0, H=7 -> zero oPlot pulses; oDone=1 one cycle after acceptance. iStart pulsed during a running FILL -> ignored; latched X/Y unchanged.
- (VGA_RECT_OUTLINE_EN) FILL X=0, Y=0, W=5, H=4, iOutline=1 -> 20 stepping cycles with 14 oPlot pulses; interior (1..3, 1..2) is never plotted.

Source files
------------

// File: rtl/vga_rect_plotter.sv
// Rasterises one axis-aligned rectangle or a full-screen clear into VGA adapter pixel writes.
// Define VGA_RECT_OUTLINE_EN to add the iOutline input (plot only the rectangle border).
module vga_rect_plotter #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int XW              = 8,
  parameter int YW              = 7,
  parameter int CW              = 3,
  parameter int SZW             = 5
) (
  input  logic           iClock,
  input  logic           iReset,
  input  logic           iStart,
  input  logic           iClear,
  input  logic [XW-1:0]  iX,
  input  logic [YW-1:0]  iY,
  input  logic [SZW-1:0] iW,
  input  logic [SZW-1:0] iH,
  input  logic [CW-1:0]  iColour,
`ifdef VGA_RECT_OUTLINE_EN
  input  logic           iOutline,
`endif
  input  logic           iStall,
  output logic [XW-1:0]  oX,
  output logic [YW-1:0]  oY,
  output logic [CW-1:0]  oColour,
  output logic           oPlot,
  output logic           oBusy,
  output logic           oDone
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CLEAR, S_DONE} state_t;

  localparam logic [XW-1:0]  CLR_X_LAST = XW'(X_SCREEN_PIXELS - 1);
  localparam logic [YW-1:0]  CLR_Y_LAST = YW'(Y_SCREEN_PIXELS - 1);
  localparam logic [XW:0]    X_LIMIT    = (XW+1)'(X_SCREEN_PIXELS);
  localparam logic [YW:0]    Y_LIMIT    = (YW+1)'(Y_SCREEN_PIXELS);
  localparam logic [SZW-1:0] SZ_ZERO    = '0;
  localparam logic [SZW-1:0] SZ_ONE     = SZW'(1);
  localparam logic [XW-1:0]  X_ONE      = XW'(1);
  localparam logic [YW-1:0]  Y_ONE      = YW'(1);

  state_t         state, state_nxt;
  logic [SZW-1:0] dx, dy;
  logic [XW-1:0]  cx;
  logic [YW-1:0]  cy;

  logic [XW-1:0]  x0;
  logic [YW-1:0]  y0;
  logic [SZW-1:0] w_lat, h_lat;
  logic [CW-1:0]  colour_lat;

  logic           accept;
  logic           dx_last, dy_last, cx_last, cy_last;
  logic [XW:0]    fill_x;
  logic [YW:0]    fill_y;
  logic           fill_visible, fill_edge;

  assign accept  = iStart && (state == S_IDLE || state == S_DONE);
  assign dx_last = (dx == w_lat - SZ_ONE);
  assign dy_last = (dy == h_lat - SZ_ONE);
  assign cx_last = (cx == CLR_X_LAST);
  assign cy_last = (cy == CLR_Y_LAST);

  // One bit of headroom so off-screen pixels are detected rather than wrapped.
  assign fill_x       = {1'b0, x0} + (XW+1)'(dx);
  assign fill_y       = {1'b0, y0} + (YW+1)'(dy);
  assign fill_visible = (fill_x < X_LIMIT) && (fill_y < Y_LIMIT);

`ifdef VGA_RECT_OUTLINE_EN
  logic outline_lat;

  always_ff @(posedge iClock) begin
    if (accept) outline_lat <= iOutline;
  end

  assign fill_edge = !outline_lat || (dx == SZ_ZERO) || dx_last || (dy == SZ_ZERO) || dy_last;
`else
  assign fill_edge = 1'b1;
`endif

  // Command parameters are captured only on acceptance; no reset needed on data.
  always_ff @(posedge iClock) begin
    if (accept) begin
      x0         <= iX;
      y0         <= iY;
      w_lat      <= iW;
      h_lat      <= iH;
      colour_lat <= iColour;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state <= S_IDLE;
      dx    <= '0;
      dy    <= '0;
      cx    <= '0;
      cy    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dx <= '0;
        dy <= '0;
        cx <= '0;
        cy <= '0;
      end else if (!iStall) begin
        if (state == S_FILL) begin
          if (dx_last) begin
            dx <= '0;
            dy <= dy + SZ_ONE;
          end else begin
            dx <= dx + SZ_ONE;
          end
        end
        if (state == S_CLEAR) begin
          if (cx_last) begin
            cx <= '0;
            cy <= cy + Y_ONE;
          end else begin
            cx <= cx + X_ONE;
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (iStart) begin
          if (iClear)                           state_nxt = S_CLEAR;
          else if (iW == SZ_ZERO || iH == SZ_ZERO) state_nxt = S_DONE;
          else                                  state_nxt = S_FILL;
        end
      end
      S_FILL:  if (!iStall && dx_last && dy_last) state_nxt = S_DONE;
      S_CLEAR: if (!iStall && cx_last && cy_last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs derive from registered state/counters, so stall holds them and reset clears them at once.
  always_comb begin
    oX      = '0;
    oY      = '0;
    oColour = '0;
    oPlot   = 1'b0;
    oBusy   = 1'b0;
    oDone   = 1'b0;
    case (state)
      S_FILL: begin
        oX      = fill_x[XW-1:0];
        oY      = fill_y[YW-1:0];
        oColour = colour_lat;
        oPlot   = fill_visible && fill_edge;
        oBusy   = 1'b1;
      end
      S_CLEAR: begin
        oX      = cx;
        oY      = cy;
        oColour = colour_lat;
        oPlot   = 1'b1;
        oBusy   = 1'b1;
      end
      S_DONE:  oDone = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Scoreboard bench for vga_rect_plotter: stimulus queues expected pixels, a negedge monitor pops and compares.
module tb_vga_rect_plotter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, clr_cmd, stall;
  logic [7:0] ix;
  logic [6:0] iy;
  logic [4:0] iw, ih;
  logic [2:0] icol;
`ifdef VGA_RECT_OUTLINE_EN
  logic       outline;
`endif
  logic [7:0] ox;
  logic [6:0] oy;
  logic [2:0] ocol;
  logic       oplot, obusy, odone;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         plot_cnt = 0;
  logic       prev_hold = 1'b0;
  logic [18:0] prev_vec;

  always #5 clk = ~clk;

  vga_rect_plotter dut (
    .iClock  (clk),
    .iReset  (rst),
    .iStart  (start),
    .iClear  (clr_cmd),
    .iX      (ix),
    .iY      (iy),
    .iW      (iw),
    .iH      (ih),
    .iColour (icol),
`ifdef VGA_RECT_OUTLINE_EN
    .iOutline(outline),
`endif
    .iStall  (stall),
    .oX      (ox),
    .oY      (oy),
    .oColour (ocol),
    .oPlot   (oplot),
    .oBusy   (obusy),
    .oDone   (odone)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every pixel the adapter accepts must be the next expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold && obusy)
        chk("stall_hold", {ox, oy, ocol, oplot}, prev_vec);
      if (oplot && !stall) begin
        plot_cnt++;
        if (exp_q.size() == 0) chk("unexpected_plot", {ox, oy}, 64'hFFFF_FFFF);
        else chk("pixel", {ox, oy, ocol}, exp_q.pop_front());
      end
      prev_hold = stall && obusy;
      prev_vec  = {ox, oy, ocol, oplot};
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic push_rect(input int x, input int y, input int w, input int h, input int col,
                           input bit outl);
    for (int dy = 0; dy < h; dy++)
      for (int dx = 0; dx < w; dx++)
        if (x + dx < 160 && y + dy < 120 &&
            (!outl || dx == 0 || dx == w - 1 || dy == 0 || dy == h - 1))
          exp_q.push_back({8'(x + dx), 7'(y + dy), 3'(col)});
  endtask

  // mode: 0 plain, 1 stall 1-of-3 cycles, 2 extra iStart mid-command, 3 iStall high with iStart.
  // exp_n: cycle (1 = first after acceptance) at which oDone must be seen; 0 = don't check.
  task automatic run_cmd(input string tag, input logic c, input int x, input int y,
                         input int w, input int h, input int col, input bit outl,
                         input int mode, input int exp_n);
    int n;
    int limit;
    clr_cmd = c;
    ix = 8'(x); iy = 7'(y); iw = 5'(w); ih = 5'(h); icol = 3'(col);
`ifdef VGA_RECT_OUTLINE_EN
    outline = outl;
`endif
    start = 1'b1;
    if (mode == 3) stall = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stall = 1'b0;
    n = 1;
    if (exp_n != 1) chk({tag, "_busy"}, obusy, 1);
    limit = c ? 40000 : 2000;
    while (!odone && n < limit) begin
      if (mode == 1) stall = (n % 3 == 2);
      if (mode == 2) begin
        start = (n == 2);
        if (n == 2) begin ix = 8'd100; iy = 7'd100; clr_cmd = 1'b1; end
      end
      @(posedge clk); #1;
      n++;
    end
    stall = 1'b0;
    start = 1'b0;
    chk({tag, "_done"}, odone, 1);
    if (exp_n != 0) chk({tag, "_done_cycle"}, n, exp_n);
    chk({tag, "_idle_busy"}, obusy, 0);
    chk({tag, "_idle_plot"}, oplot, 0);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; start = 1'b0; clr_cmd = 1'b0; stall = 1'b0;
    ix = '0; iy = '0; iw = '0; ih = '0; icol = '0;
`ifdef VGA_RECT_OUTLINE_EN
    outline = 1'b0;
`endif
    #1;
    chk("rst_outputs", {ox, oy, ocol, oplot, obusy, odone}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", {ox, oy, ocol, oplot, obusy, odone}, 0);

    // Reset in the middle of a CLEAR.
    for (int p = 0; p < 19200; p++) exp_q.push_back({8'(p % 160), 7'(p / 160), 3'd3});
    clr_cmd = 1'b1; icol = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = plot_cnt;
    n = 0;
    while (plot_cnt - base < 500 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clear_reached_500", plot_cnt - base, 500);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outputs", {ox, oy, ocol, oplot, obusy, odone}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    base = plot_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_no_plot", plot_cnt - base, 0);
    chk("post_rst_idle", {obusy, odone}, 0);

    // 4x4 fill: 16 pixels then oDone on cycle 17.
    push_rect(10, 20, 4, 4, 5, 0);
    run_cmd("fill4x4", 1'b0, 10, 20, 4, 4, 5, 0, 0, 17);

    // Corner-clipped 3x3: only four on-screen pixels, stall asserted with iStart in DONE.
    exp_q.push_back({8'd158, 7'd118, 3'd6});
    exp_q.push_back({8'd159, 7'd118, 3'd6});
    exp_q.push_back({8'd158, 7'd119, 3'd6});
    exp_q.push_back({8'd159, 7'd119, 3'd6});
    base = plot_cnt;
    run_cmd("clip3x3", 1'b0, 158, 118, 3, 3, 6, 0, 3, 10);
    chk("clip3x3_plots", plot_cnt - base, 4);

    // Zero width: no pixels, done one cycle after acceptance.
    base = plot_cnt;
    run_cmd("zero_w", 1'b0, 30, 30, 0, 7, 1, 0, 0, 1);
    chk("zero_w_plots", plot_cnt - base, 0);

    // Second iStart during FILL must not alter the running command.
    push_rect(40, 50, 3, 2, 2, 0);
    run_cmd("restart_ignored", 1'b0, 40, 50, 3, 2, 2, 0, 2, 7);

    // Full clear with periodic stalls.
    for (int p = 0; p < 19200; p++) exp_q.push_back({8'(p % 160), 7'(p / 160), 3'd0});
    base = plot_cnt;
    run_cmd("clear_stall", 1'b1, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("clear_plots", plot_cnt - base, 19200);

`ifdef VGA_RECT_OUTLINE_EN
    push_rect(0, 0, 5, 4, 7, 1);
    base = plot_cnt;
    run_cmd("outline5x4", 1'b0, 0, 0, 5, 4, 7, 1, 0, 21);
    chk("outline_plots", plot_cnt - base, 14);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
